// File: rtl/round_pkg.sv
// Shared mode encoding and width helper for the round_shift_pipe slice.
package round_pkg;

    typedef enum logic [1:0] {
        MODE_RTZ_EXM1 = 2'd0,
        MODE_RTZ      = 2'd1,
        MODE_FLOOR    = 2'd2,
        MODE_RNE      = 2'd3
    } mode_t;

    function automatic int calc_ow(input int width, input int shift);
        return width - shift;
    endfunction

endpackage

// File: rtl/round_lane.sv
// One lane of the rounding unit: stage-1 decode of the raw input and stage-2
// combine of the registered decode into the rounded, saturated result.
module round_lane
    import round_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHIFT = 4
) (
    input  logic [WIDTH-1:0]       data_i,
    output logic [WIDTH-SHIFT-1:0] fl_o,
    output logic                   nz_o,
    output logic                   gt_o,
    output logic                   eq_o,
    output logic                   neg_o,
    output logic                   rng_o,
    input  logic [WIDTH-SHIFT-1:0] fl_i,
    input  logic                   nz_i,
    input  logic                   gt_i,
    input  logic                   eq_i,
    input  logic                   neg_i,
    input  logic                   rng_i,
    input  mode_t                  mode_i,
    output logic [WIDTH-SHIFT-1:0] res_o,
    output logic                   sat_o
);

    localparam int OW = calc_ow(WIDTH, SHIFT);
    localparam logic [OW-1:0] OW_MAX = {1'b0, {(OW-1){1'b1}}};

    typedef struct packed {
        logic [OW-1:0] fl;
        logic          nz;
        logic          gt;
        logic          eq;
        logic          neg;
        logic          rng;
    } dec_t;

    typedef struct packed {
        logic [OW-1:0] res;
        logic          sat;
    } out_t;

    function automatic dec_t decode(input logic [WIDTH-1:0] v);
        dec_t             d;
        logic [SHIFT-1:0] fr;
        logic [SHIFT-1:0] half;
        fr    = v[SHIFT-1:0];
        half  = SHIFT'(1) << (SHIFT - 1);
        d.fl  = v[WIDTH-1:SHIFT];
        d.nz  = |fr;
        d.gt  = fr > half;
        d.eq  = fr == half;
        d.neg = v[WIDTH-1];
        // v in (-2^SHIFT, 0) is exactly floor == -1 with a nonzero fraction
        d.rng = d.neg && (&d.fl) && d.nz;
        return d;
    endfunction

    function automatic out_t combine(input dec_t d, input mode_t m);
        out_t r;
        logic up;
        r.sat = 1'b0;
        r.res = d.fl;
        up    = 1'b0;
        unique case (m)
            MODE_FLOOR:    up = 1'b0;
            MODE_RTZ:      up = d.neg && d.nz;
            MODE_RTZ_EXM1: up = d.neg && d.nz;
            MODE_RNE:      up = d.gt || (d.eq && d.fl[0]);
            default:       up = 1'b0;
        endcase
        if (m == MODE_RNE && up && d.fl == OW_MAX) begin
            r.sat = 1'b1;
        end else begin
            r.res = d.fl + OW'(up);
        end
        if (m == MODE_RTZ_EXM1 && d.rng) begin
            r.res = '1;
        end
        return r;
    endfunction

    dec_t dec_s;
    dec_t reg_s;
    out_t out_s;

    assign reg_s = '{fl: fl_i, nz: nz_i, gt: gt_i, eq: eq_i, neg: neg_i, rng: rng_i};

    always_comb begin
        dec_s = decode(data_i);
        out_s = combine(reg_s, mode_i);
    end

    assign fl_o  = dec_s.fl;
    assign nz_o  = dec_s.nz;
    assign gt_o  = dec_s.gt;
    assign eq_o  = dec_s.eq;
    assign neg_o = dec_s.neg;
    assign rng_o = dec_s.rng;
    assign res_o = out_s.res;
    assign sat_o = out_s.sat;

endmodule

// File: rtl/round_shift_pipe.sv
// Multi-lane two-stage fixed-point rounding pipeline with valid/ready on both
// sides and a sticky-saturating count of lane saturation events.
module round_shift_pipe
    import round_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHIFT = 4,
    parameter int LANES = 2,
    parameter int CNT_W = 16
) (
    input  logic                           i_clk,
    input  logic                           i_nRst,
    input  logic                           i_valid,
    output logic                           o_ready,
    input  logic [1:0]                     i_mode,
    input  logic [LANES*WIDTH-1:0]         i_data,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic [LANES*(WIDTH-SHIFT)-1:0] o_data,
    output logic [LANES-1:0]               o_sat,
    input  logic                           i_cntClr,
    output logic [CNT_W-1:0]               o_satCnt
);

    localparam int OW = calc_ow(WIDTH, SHIFT);

    logic                      s1_valid_q;
    logic [LANES-1:0][OW-1:0]  s1_fl_q,  s1_fl_d;
    logic [LANES-1:0]          s1_nz_q,  s1_nz_d;
    logic [LANES-1:0]          s1_gt_q,  s1_gt_d;
    logic [LANES-1:0]          s1_eq_q,  s1_eq_d;
    logic [LANES-1:0]          s1_neg_q, s1_neg_d;
    logic [LANES-1:0]          s1_rng_q, s1_rng_d;
    mode_t                     s1_mode_q;

    logic                      s2_valid_q;
    logic [LANES-1:0][OW-1:0]  s2_data_q, s2_data_d;
    logic [LANES-1:0]          s2_sat_q,  s2_sat_d;

    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [CNT_W:0]            pop_s, sum_s;
    logic                      s1_adv;
    logic                      out_hs;

    assign s1_adv  = !s2_valid_q || i_ready;
    assign o_ready = !s1_valid_q || s1_adv;
    assign out_hs  = s2_valid_q && i_ready;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        round_lane #(
            .WIDTH(WIDTH),
            .SHIFT(SHIFT)
        ) u_lane (
            .data_i (i_data[k*WIDTH +: WIDTH]),
            .fl_o   (s1_fl_d[k]),
            .nz_o   (s1_nz_d[k]),
            .gt_o   (s1_gt_d[k]),
            .eq_o   (s1_eq_d[k]),
            .neg_o  (s1_neg_d[k]),
            .rng_o  (s1_rng_d[k]),
            .fl_i   (s1_fl_q[k]),
            .nz_i   (s1_nz_q[k]),
            .gt_i   (s1_gt_q[k]),
            .eq_i   (s1_eq_q[k]),
            .neg_i  (s1_neg_q[k]),
            .rng_i  (s1_rng_q[k]),
            .mode_i (s1_mode_q),
            .res_o  (s2_data_d[k]),
            .sat_o  (s2_sat_d[k])
        );
    end

    // Clear dominates; otherwise add this beat's saturated lanes, pinning at all-ones
    always_comb begin
        pop_s = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            pop_s = pop_s + (CNT_W+1)'(s2_sat_q[k]);
        end
        sum_s = {1'b0, cnt_q} + pop_s;
        cnt_d = cnt_q;
        if (out_hs) begin
            cnt_d = sum_s[CNT_W] ? '1 : sum_s[CNT_W-1:0];
        end
        if (i_cntClr) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_nRst) begin
        if (!i_nRst) begin
            s1_valid_q <= 1'b0;
            s1_fl_q    <= '0;
            s1_nz_q    <= '0;
            s1_gt_q    <= '0;
            s1_eq_q    <= '0;
            s1_neg_q   <= '0;
            s1_rng_q   <= '0;
            s1_mode_q  <= MODE_RTZ_EXM1;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_sat_q   <= '0;
            cnt_q      <= '0;
        end else begin
            if (o_ready) begin
                s1_valid_q <= i_valid;
                if (i_valid) begin
                    s1_fl_q   <= s1_fl_d;
                    s1_nz_q   <= s1_nz_d;
                    s1_gt_q   <= s1_gt_d;
                    s1_eq_q   <= s1_eq_d;
                    s1_neg_q  <= s1_neg_d;
                    s1_rng_q  <= s1_rng_d;
                    s1_mode_q <= mode_t'(i_mode);
                end
            end
            if (s1_adv) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_data_q <= s2_data_d;
                    s2_sat_q  <= s2_sat_d;
                end
            end
            cnt_q <= cnt_d;
        end
    end

    assign o_valid  = s2_valid_q;
    assign o_data   = s2_data_q;
    assign o_sat    = s2_sat_q;
    assign o_satCnt = cnt_q;

endmodule

// File: tb/tb_round_shift_pipe.sv
// Randomized and directed bench for round_shift_pipe against an integer
// arithmetic reference model and an in-order scoreboard.
module tb_round_shift_pipe;

    localparam int WIDTH = 16;
    localparam int SHIFT = 4;
    localparam int LANES = 2;
    localparam int CNT_W = 4;
    localparam int OW    = WIDTH - SHIFT;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   i_valid = 1'b0;
    logic                   o_ready;
    logic [1:0]             i_mode = 2'd0;
    logic [LANES*WIDTH-1:0] i_data = '0;
    logic                   o_valid;
    logic                   i_ready = 1'b1;
    logic [LANES*OW-1:0]    o_data;
    logic [LANES-1:0]       o_sat;
    logic                   i_cntClr = 1'b0;
    logic [CNT_W-1:0]       o_satCnt;

    round_shift_pipe #(
        .WIDTH(WIDTH),
        .SHIFT(SHIFT),
        .LANES(LANES),
        .CNT_W(CNT_W)
    ) dut (
        .i_clk    (clk),
        .i_nRst   (rst_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_mode   (i_mode),
        .i_data   (i_data),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_data   (o_data),
        .o_sat    (o_sat),
        .i_cntClr (i_cntClr),
        .o_satCnt (o_satCnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  m;
        logic [23:0] ed;
        logic [1:0]  es;
        int          acc;
    } beat_t;

    beat_t in_q[$];
    beat_t exp_q[$];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int n_out  = 0;
    int cnt_m  = 0;
    bit lat_chk   = 1'b0;
    bit clr_arm   = 1'b0;
    bit stall_prev = 1'b0;
    logic [25:0] held;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    endtask

    // Reference rounding on plain integers; returns {sat, 12-bit result}
    function automatic logic [12:0] ref_round(input logic [15:0] raw, input logic [1:0] mode);
        int v, r, qf, q;
        logic [31:0] qq;
        logic sat;
        v  = int'($signed(raw));
        r  = ((v % 16) + 16) % 16;
        qf = (v - r) / 16;
        case (mode)
            2'd2: q = qf;
            2'd1: q = v / 16;
            2'd0: q = (v < 0 && v > -16) ? -1 : v / 16;
            default: q = qf + (((r > 8) || (r == 8 && (qf % 2) != 0)) ? 1 : 0);
        endcase
        sat = (q > 2047);
        if (sat) q = 2047;
        qq = q;
        return {sat, qq[11:0]};
    endfunction

    task automatic push_model(input logic [15:0] d0, input logic [15:0] d1, input logic [1:0] m);
        beat_t b;
        logic [12:0] r0, r1;
        r0 = ref_round(d0, m);
        r1 = ref_round(d1, m);
        b.d = {d1, d0}; b.m = m; b.ed = {r1[11:0], r0[11:0]}; b.es = {r1[12], r0[12]}; b.acc = 0;
        in_q.push_back(b);
    endtask

    task automatic push_exp(input logic [31:0] d, input logic [1:0] m,
                            input logic [23:0] ed, input logic [1:0] es);
        beat_t b;
        b.d = d; b.m = m; b.ed = ed; b.es = es; b.acc = 0;
        in_q.push_back(b);
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (in_q.size() == 0 && exp_q.size() == 0) break;
        end
        chk("drain", 64'(in_q.size() + exp_q.size()), 0);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (in_q.size() > 0) begin
            i_valid = 1'b1;
            i_data  = in_q[0].d;
            i_mode  = in_q[0].m;
        end else begin
            i_valid = 1'b0;
        end
    end

    always @(negedge clk) begin
        beat_t b;
        bit hs;
        int pc;
        if (!rst_n) begin
            cnt_m = 0;
            stall_prev = 1'b0;
            i_cntClr = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_v", 64'(o_valid), 1);
                chk("hold_d", 64'({o_sat, o_data}), 64'(held));
            end
            chk("satcnt", 64'(o_satCnt), 64'(cnt_m));
            hs = o_valid && i_ready;
            i_cntClr = clr_arm && hs;
            if (i_cntClr) clr_arm = 1'b0;
            if (hs) begin
                if (exp_q.size() == 0) begin
                    chk("spurious", 64'(o_valid), 0);
                end else begin
                    b = exp_q.pop_front();
                    chk("data", 64'(o_data), 64'(b.ed));
                    chk("sat", 64'(o_sat), 64'(b.es));
                    if (lat_chk) chk("lat", 64'(cyc - b.acc), 2);
                end
                n_out++;
                pc = int'(o_sat[0]) + int'(o_sat[1]);
                if (i_cntClr) cnt_m = 0;
                else cnt_m = (cnt_m + pc > 15) ? 15 : cnt_m + pc;
            end
            if (i_valid && o_ready && in_q.size() > 0) begin
                b = in_q.pop_front();
                b.acc = cyc;
                exp_q.push_back(b);
            end
            stall_prev = o_valid && !i_ready;
            held = {o_sat, o_data};
        end
    end

    logic [15:0] sv_vals [5] = '{16'h0018, 16'h0028, 16'hFFE8, 16'hFFF8, 16'h0008};
    logic [11:0] sv_tbl  [4][5] = '{
        '{12'h001, 12'h002, 12'hFFF, 12'hFFF, 12'h000},
        '{12'h001, 12'h002, 12'hFFF, 12'h000, 12'h000},
        '{12'h001, 12'h002, 12'hFFE, 12'hFFF, 12'h000},
        '{12'h002, 12'h002, 12'hFFE, 12'h000, 12'h000}
    };

    initial begin
        int n0;
        logic [15:0] a, b;

        #1;
        chk("rst_valid", 64'(o_valid), 0);
        chk("rst_data", 64'(o_data), 0);
        chk("rst_sat", 64'(o_sat), 0);
        chk("rst_cnt", 64'(o_satCnt), 0);
        chk("rst_ready", 64'(o_ready), 1);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // mode sweep, each mode across the five table values
        for (int m = 0; m < 4; m++)
            for (int i = 0; i < 5; i++)
                push_exp({sv_vals[(i+1)%5], sv_vals[i]}, 2'(m),
                         {sv_tbl[m][(i+1)%5], sv_tbl[m][i]}, 2'b00);
        drain();

        // saturation and counter clear
        chk("cnt0", 64'(o_satCnt), 0);
        push_exp({16'h0000, 16'h7FF8}, 2'd3, {12'h000, 12'h7FF}, 2'b01);
        drain();
        chk("cnt1", 64'(o_satCnt), 1);
        clr_arm = 1'b1;
        push_exp({16'h0000, 16'h7FF8}, 2'd3, {12'h000, 12'h7FF}, 2'b01);
        drain();
        chk("cntclr", 64'(o_satCnt), 0);

        // back-to-back with alternating modes
        lat_chk = 1'b1;
        n0 = n_out;
        for (int i = 0; i < 8; i++)
            push_model(16'($urandom), 16'($urandom), 2'(i % 4));
        drain();
        chk("b2b_n", 64'(n_out - n0), 8);
        lat_chk = 1'b0;

        // backpressure
        n0 = n_out;
        for (int i = 0; i < 6; i++)
            push_model(16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)));
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (o_valid) break;
        end
        chk("bp_first", 64'(o_valid), 1);
        @(posedge clk); #1 i_ready = 1'b0;
        @(negedge clk);
        chk("bp_rdy", 64'(o_ready), 0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1 i_ready = 1'b1;
        drain();
        chk("bp_n", 64'(n_out - n0), 6);

        // counter sticks at all-ones
        for (int i = 0; i < 10; i++) push_model(16'h7FF8, 16'h7FFC, 2'd3);
        drain();
        chk("stick", 64'(o_satCnt), 64'hF);
        for (int i = 0; i < 2; i++) push_model(16'h7FF9, 16'h7FF8, 2'd3);
        drain();
        chk("stick2", 64'(o_satCnt), 64'hF);

        // random stream with random backpressure
        for (int i = 0; i < 40; i++) begin
            a = ($urandom_range(0, 3) == 0) ? 16'(16'h7FF0 + $urandom_range(0, 15)) : 16'($urandom);
            b = ($urandom_range(0, 3) == 0) ? 16'(16'hFFF0 + $urandom_range(0, 15)) : 16'($urandom);
            push_model(a, b, 2'($urandom_range(0, 3)));
        end
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1 i_ready = ($urandom_range(0, 3) != 0);
            if (in_q.size() == 0 && exp_q.size() == 0) break;
        end
        i_ready = 1'b1;
        drain();

        // reset with both stages full
        i_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_model(16'($urandom), 16'($urandom), 2'd1);
        repeat (6) @(negedge clk);
        chk("full_v", 64'(o_valid), 1);
        chk("full_rdy", 64'(o_ready), 0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        in_q.delete();
        exp_q.delete();
        i_valid = 1'b0;
        #1;
        chk("mrst_valid", 64'(o_valid), 0);
        chk("mrst_data", 64'(o_data), 0);
        chk("mrst_cnt", 64'(o_satCnt), 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        i_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_idle", 64'(o_valid), 0);
        end
        lat_chk = 1'b1;
        push_model(16'h0018, 16'hFFE8, 2'd3);
        drain();
        lat_chk = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
